// File: rtl/nes_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : nes_line_buffer
// Purpose  : Double-buffered scanline store between the PPU pixel stream and
//            the VGA timing generator. The PPU fills one 256 x 6-bit bank
//            while the VGA side reads the other. Palette indices go through
//            the NES 2C02 master palette. RGB, sync and blank are registered
//            in a 2-stage pipe, so all outputs are aligned.
// Ports    : Clk, Reset_n (synchronous, active low)
//            pix_valid/pix_idx/pix_ready : PPU pixel handshake
//            ppu_sof                     : PPU start-of-frame pulse
//            DrawX/DrawY                 : VGA pixel counters
//            hs_in/vs_in/blank_in        : VGA sync/blank (blank_in=1 visible)
//            Red/Green/Blue              : registered colour, 2 cycles latency
//            hs_out/vs_out/blank_out     : sync/blank delayed by 2 cycles
//            underrun/underrun_cnt       : sticky flag / saturating count
// Options  : `define UNDERRUN_CHECK_EN enables the underrun flag and counter.
//            When it is not defined, both are tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module nes_line_buffer #(
  parameter int LINE_W = 256,
  parameter int LINES  = 240
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        pix_valid,
  input  logic [5:0]  pix_idx,
  output logic        pix_ready,
  input  logic        ppu_sof,
  input  logic [10:0] DrawX,
  input  logic [10:0] DrawY,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        blank_in,
  output logic [7:0]  Red,
  output logic [7:0]  Green,
  output logic [7:0]  Blue,
  output logic        hs_out,
  output logic        vs_out,
  output logic        blank_out,
  output logic        underrun,
  output logic [15:0] underrun_cnt
);

  localparam logic [10:0] c_line_w = 11'(LINE_W);
  localparam logic [10:0] c_lines  = 11'(LINES);
  localparam logic [10:0] c_last_x = 11'(LINE_W - 1);

  // Both banks live in one array; the bank number is the address MSB.
  logic [5:0]  r_mem [0:511];
  logic [1:0]  r_full;
  logic        r_wr_bank;
  logic [7:0]  r_wr_ptr;
  logic        r_line_ok;

  logic        w_rd_bank;
  logic        w_active;
  logic        w_line_start;
  logic        w_line_ok;
  logic        w_consume;
  logic        w_swap;
  logic        w_accept;
  logic        w_last;
  logic [7:0]  w_wr_addr;

  logic [5:0]  r_rd_idx;
  logic        r_vis1;
  logic        r_hs1;
  logic        r_vs1;
  logic        r_blank1;
  logic [23:0] w_rgb;

  assign w_rd_bank    = ~r_wr_bank;
  assign pix_ready    = ~r_full[r_wr_bank];
  assign w_accept     = pix_valid && pix_ready;
  // A pixel arriving with ppu_sof restarts the line at index 0.
  assign w_wr_addr    = ppu_sof ? 8'd0 : r_wr_ptr;
  assign w_last       = (w_wr_addr == 8'hFF);
  assign w_active     = (DrawX < c_line_w) && (DrawY < c_lines);
  assign w_line_start = (DrawX == 11'd0) && (DrawY < c_lines);
  // Pixel 0 must see this line's flag, not the one latched for the last line.
  assign w_line_ok    = w_line_start ? r_full[w_rd_bank] : r_line_ok;
  assign w_consume    = (DrawX == c_last_x) && (DrawY < c_lines) && r_line_ok;
  // ppu_sof keeps wr_bank where it is, so it also suppresses a swap.
  assign w_swap       = !w_active && r_full[r_wr_bank] && !r_full[w_rd_bank] && !ppu_sof;

  // Buffer control: flags, write pointer, bank select, line qualifier.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_full    <= 2'b00;
      r_wr_bank <= 1'b0;
      r_wr_ptr  <= 8'd0;
      r_line_ok <= 1'b0;
    end else begin
      if (w_line_start) begin
        r_line_ok <= r_full[w_rd_bank];
      end
      if (ppu_sof) begin
        r_full   <= 2'b00;
        r_wr_ptr <= w_accept ? 8'd1 : 8'd0;
      end else begin
        if (w_accept) begin
          r_wr_ptr <= r_wr_ptr + 8'd1;   // wraps to 0 after index 255
          if (w_last) begin
            r_full[r_wr_bank] <= 1'b1;
          end
        end
        if (w_consume) begin
          r_full[w_rd_bank] <= 1'b0;
        end
        if (w_swap) begin
          r_wr_bank <= ~r_wr_bank;
        end
      end
    end
  end

  // Bank storage; contents need no reset because the full flags gate use.
  always_ff @(posedge Clk) begin
    if (Reset_n && w_accept) begin
      r_mem[{r_wr_bank, w_wr_addr}] <= pix_idx;
    end
  end

  // Read pipe: stage 1 registers the RAM word, stage 2 the palette colour.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_rd_idx  <= 6'd0;
      r_vis1    <= 1'b0;
      r_hs1     <= 1'b1;
      r_vs1     <= 1'b1;
      r_blank1  <= 1'b0;
      Red       <= 8'd0;
      Green     <= 8'd0;
      Blue      <= 8'd0;
      hs_out    <= 1'b1;
      vs_out    <= 1'b1;
      blank_out <= 1'b0;
    end else begin
      r_rd_idx  <= r_mem[{w_rd_bank, DrawX[7:0]}];
      r_vis1    <= w_active && w_line_ok;
      r_hs1     <= hs_in;
      r_vs1     <= vs_in;
      r_blank1  <= blank_in;
      hs_out    <= r_hs1;
      vs_out    <= r_vs1;
      blank_out <= r_blank1;
      if (r_blank1 && r_vis1) begin
        {Red, Green, Blue} <= w_rgb;
      end else begin
        {Red, Green, Blue} <= 24'h000000;
      end
    end
  end

  // NES 2C02 master palette; the unlisted entries are black.
  function automatic logic [23:0] nes_palette(input logic [5:0] idx);
    case (idx)
      6'h00: nes_palette = 24'h7C7C7C;  6'h01: nes_palette = 24'h0000FC;
      6'h02: nes_palette = 24'h0000BC;  6'h03: nes_palette = 24'h4428BC;
      6'h04: nes_palette = 24'h940084;  6'h05: nes_palette = 24'hA80020;
      6'h06: nes_palette = 24'hA81000;  6'h07: nes_palette = 24'h881400;
      6'h08: nes_palette = 24'h503000;  6'h09: nes_palette = 24'h007800;
      6'h0A: nes_palette = 24'h006800;  6'h0B: nes_palette = 24'h005800;
      6'h0C: nes_palette = 24'h004058;
      6'h10: nes_palette = 24'hBCBCBC;  6'h11: nes_palette = 24'h0078F8;
      6'h12: nes_palette = 24'h0058F8;  6'h13: nes_palette = 24'h6844FC;
      6'h14: nes_palette = 24'hD800CC;  6'h15: nes_palette = 24'hE40058;
      6'h16: nes_palette = 24'hF83800;  6'h17: nes_palette = 24'hE45C10;
      6'h18: nes_palette = 24'hAC7C00;  6'h19: nes_palette = 24'h00B800;
      6'h1A: nes_palette = 24'h00A800;  6'h1B: nes_palette = 24'h00A844;
      6'h1C: nes_palette = 24'h008888;
      6'h20: nes_palette = 24'hF8F8F8;  6'h21: nes_palette = 24'h3CBCFC;
      6'h22: nes_palette = 24'h6888FC;  6'h23: nes_palette = 24'h9878F8;
      6'h24: nes_palette = 24'hF878F8;  6'h25: nes_palette = 24'hF85898;
      6'h26: nes_palette = 24'hF87858;  6'h27: nes_palette = 24'hFCA044;
      6'h28: nes_palette = 24'hF8B800;  6'h29: nes_palette = 24'hB8F818;
      6'h2A: nes_palette = 24'h58D854;  6'h2B: nes_palette = 24'h58F898;
      6'h2C: nes_palette = 24'h00E8D8;  6'h2D: nes_palette = 24'h787878;
      6'h30: nes_palette = 24'hFCFCFC;  6'h31: nes_palette = 24'hA4E4FC;
      6'h32: nes_palette = 24'hB8B8F8;  6'h33: nes_palette = 24'hD8B8F8;
      6'h34: nes_palette = 24'hF8B8F8;  6'h35: nes_palette = 24'hF8A4C0;
      6'h36: nes_palette = 24'hF0D0B0;  6'h37: nes_palette = 24'hFCE0A8;
      6'h38: nes_palette = 24'hF8D878;  6'h39: nes_palette = 24'hD8F878;
      6'h3A: nes_palette = 24'hB8F8B8;  6'h3B: nes_palette = 24'hB8F8D8;
      6'h3C: nes_palette = 24'h00FCFC;  6'h3D: nes_palette = 24'hF8D8F8;
      default: nes_palette = 24'h000000;
    endcase
  endfunction

  always_comb begin
    w_rgb = nes_palette(r_rd_idx);
  end

`ifdef UNDERRUN_CHECK_EN
  // An underrun is a visible line starting with nothing buffered to show.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      underrun     <= 1'b0;
      underrun_cnt <= 16'd0;
    end else if (w_line_start && !r_full[w_rd_bank]) begin
      underrun <= 1'b1;
      if (underrun_cnt != 16'hFFFF) begin
        underrun_cnt <= underrun_cnt + 16'd1;
      end
    end
  end
`else
  assign underrun     = 1'b0;
  assign underrun_cnt = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nes_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_nes_line_buffer
// Purpose  : Directed self-checking bench for nes_line_buffer. Covers reset,
//            fill/display, back-pressure, underrun, mid-line SOF and blanking.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nes_line_buffer;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        pix_valid;
  logic [5:0]  pix_idx;
  logic        pix_ready;
  logic        ppu_sof;
  logic [10:0] DrawX;
  logic [10:0] DrawY;
  logic        hs_in, vs_in, blank_in;
  logic [7:0]  Red, Green, Blue;
  logic        hs_out, vs_out, blank_out;
  logic        underrun;
  logic [15:0] underrun_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Outputs captured per DrawX step; entry x holds the result for pixel x-1.
  logic [23:0] rgb_log   [0:259];
  logic        hs_log    [0:259];
  logic        vs_log    [0:259];
  logic        blank_log [0:259];
  logic        ready_log [0:259];

`ifdef UNDERRUN_CHECK_EN
  localparam logic        c_exp_ur  = 1'b1;
  localparam logic [15:0] c_exp_cnt = 16'd3;
`else
  localparam logic        c_exp_ur  = 1'b0;
  localparam logic [15:0] c_exp_cnt = 16'd0;
`endif

  nes_line_buffer #(.LINE_W(256), .LINES(240)) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .pix_valid    (pix_valid),
    .pix_idx      (pix_idx),
    .pix_ready    (pix_ready),
    .ppu_sof      (ppu_sof),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .hs_in        (hs_in),
    .vs_in        (vs_in),
    .blank_in     (blank_in),
    .Red          (Red),
    .Green        (Green),
    .Blue         (Blue),
    .hs_out       (hs_out),
    .vs_out       (vs_out),
    .blank_out    (blank_out),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_idle();
    DrawX = 11'd300; DrawY = 11'd250; hs_in = 1'b1; vs_in = 1'b1; blank_in = 1'b0;
  endtask

  task automatic write_px(input logic [5:0] idx);
    pix_valid = 1'b1; pix_idx = idx;
    tick();
    pix_valid = 1'b0;
  endtask

  // Scans DrawX 0..259 on line y; sync pulses low at sync_low_x, blank_in
  // drops at blank_low_x.
  task automatic run_line(input int y, input logic blank_en, input int sync_low_x, input int blank_low_x);
    for (int x = 0; x < 260; x++) begin
      DrawX    = 11'(x);
      DrawY    = 11'(y);
      hs_in    = (x != sync_low_x);
      vs_in    = (x != sync_low_x);
      blank_in = blank_en && (x < 256) && (x != blank_low_x);
      tick();
      rgb_log[x]   = {Red, Green, Blue};
      hs_log[x]    = hs_out;
      vs_log[x]    = vs_out;
      blank_log[x] = blank_out;
      ready_log[x] = pix_ready;
    end
    set_idle();
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; pix_valid = 1'b1; pix_idx = 6'h15; ppu_sof = 1'b0;
    DrawX = 11'd0; DrawY = 11'd0; hs_in = 1'b0; vs_in = 1'b0; blank_in = 1'b1;
    repeat (4) tick();
    n_checks++; if ({Red, Green, Blue} !== 24'h0) begin n_fail++; $display("FAIL reset_rgb: got %h expected %h", {Red, Green, Blue}, 24'h0); end
    n_checks++; if (hs_out !== 1'b1) begin n_fail++; $display("FAIL reset_hs: got %b expected 1", hs_out); end
    n_checks++; if (vs_out !== 1'b1) begin n_fail++; $display("FAIL reset_vs: got %b expected 1", vs_out); end
    n_checks++; if (blank_out !== 1'b0) begin n_fail++; $display("FAIL reset_blank: got %b expected 0", blank_out); end
    n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
    n_checks++; if (underrun_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_ucnt: got %0d expected 0", underrun_cnt); end
    n_checks++; if (pix_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", pix_ready); end
    pix_valid = 1'b0;
    set_idle();
    Reset_n = 1'b1;
    tick();
  endtask

  task automatic test_fill_display();
    // Bank 0: idx = x & 63
    for (int i = 0; i < 256; i++) begin
      if (i == 0 || i == 255) begin
        n_checks++; if (pix_ready !== 1'b1) begin n_fail++; $display("FAIL fill0_ready[%0d]: got %b expected 1", i, pix_ready); end
      end
      write_px(6'(i & 63));
    end
    n_checks++; if (pix_ready !== 1'b0) begin n_fail++; $display("FAIL fill0_ready_drop: got %b expected 0", pix_ready); end
    tick();
    n_checks++; if (pix_ready !== 1'b1) begin n_fail++; $display("FAIL swap_ready: got %b expected 1", pix_ready); end
    // Bank 1: idx = (x + 16) & 63
    for (int i = 0; i < 256; i++) write_px(6'((i + 16) & 63));
    tick();
    n_checks++; if (pix_ready !== 1'b0) begin n_fail++; $display("FAIL fill1_ready: got %b expected 0", pix_ready); end
  endtask

  task automatic test_backpressure_and_display();
    // Held pixel against two full banks must not land anywhere.
    pix_valid = 1'b1; pix_idx = 6'h3F;
    repeat (4) tick();
    n_checks++; if (pix_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %b expected 0", pix_ready); end
    pix_valid = 1'b0;
    run_line(0, 1'b1, 10, 999);
    n_checks++; if (rgb_log[1] !== 24'h7C7C7C) begin n_fail++; $display("FAIL l0_px0: got %h expected 7c7c7c", rgb_log[1]); end
    n_checks++; if (rgb_log[2] !== 24'h0000FC) begin n_fail++; $display("FAIL l0_px1: got %h expected 0000fc", rgb_log[2]); end
    n_checks++; if (rgb_log[34] !== 24'h3CBCFC) begin n_fail++; $display("FAIL l0_px33: got %h expected 3cbcfc", rgb_log[34]); end
    n_checks++; if (rgb_log[200] !== 24'h881400) begin n_fail++; $display("FAIL l0_px199: got %h expected 881400", rgb_log[200]); end
    n_checks++; if (hs_log[10] !== 1'b1) begin n_fail++; $display("FAIL hs_pre: got %b expected 1", hs_log[10]); end
    n_checks++; if (hs_log[11] !== 1'b0) begin n_fail++; $display("FAIL hs_delay2: got %b expected 0", hs_log[11]); end
    n_checks++; if (hs_log[12] !== 1'b1) begin n_fail++; $display("FAIL hs_post: got %b expected 1", hs_log[12]); end
    n_checks++; if (vs_log[11] !== 1'b0) begin n_fail++; $display("FAIL vs_delay2: got %b expected 0", vs_log[11]); end
    n_checks++; if (blank_log[256] !== 1'b1) begin n_fail++; $display("FAIL blank_px255: got %b expected 1", blank_log[256]); end
    n_checks++; if (blank_log[257] !== 1'b0) begin n_fail++; $display("FAIL blank_px256: got %b expected 0", blank_log[257]); end
    n_checks++; if (ready_log[100] !== 1'b0) begin n_fail++; $display("FAIL ready_midline: got %b expected 0", ready_log[100]); end
    n_checks++; if (ready_log[255] !== 1'b0) begin n_fail++; $display("FAIL ready_at_clear: got %b expected 0", ready_log[255]); end
    n_checks++; if (ready_log[256] !== 1'b1) begin n_fail++; $display("FAIL ready_after_swap: got %b expected 1", ready_log[256]); end
    run_line(1, 1'b1, 999, 999);
    n_checks++; if (rgb_log[1] !== 24'hBCBCBC) begin n_fail++; $display("FAIL l1_px0: got %h expected bcbcbc", rgb_log[1]); end
    n_checks++; if (rgb_log[2] !== 24'h0078F8) begin n_fail++; $display("FAIL l1_px1: got %h expected 0078f8", rgb_log[2]); end
  endtask

  task automatic test_underrun();
    for (int y = 2; y < 5; y++) begin
      run_line(y, 1'b1, 999, 999);
      n_checks++; if (rgb_log[1] !== 24'h0) begin n_fail++; $display("FAIL ur_px0_l%0d: got %h expected 0", y, rgb_log[1]); end
      n_checks++; if (rgb_log[34] !== 24'h0) begin n_fail++; $display("FAIL ur_px33_l%0d: got %h expected 0", y, rgb_log[34]); end
    end
    n_checks++; if (underrun !== c_exp_ur) begin n_fail++; $display("FAIL ur_flag: got %b expected %b", underrun, c_exp_ur); end
    n_checks++; if (underrun_cnt !== c_exp_cnt) begin n_fail++; $display("FAIL ur_count: got %0d expected %0d", underrun_cnt, c_exp_cnt); end
  endtask

  task automatic test_midline_sof();
    for (int i = 0; i < 256; i++) write_px(6'h07);
    tick();   // bank 0 full, swap to bank 1
    for (int i = 0; i < 100; i++) write_px(6'h05);
    ppu_sof = 1'b1;
    tick();
    ppu_sof = 1'b0;
    n_checks++; if (dut.r_full !== 2'b00) begin n_fail++; $display("FAIL sof_full: got %b expected 00", dut.r_full); end
    n_checks++; if (dut.r_wr_ptr !== 8'd0) begin n_fail++; $display("FAIL sof_ptr: got %0d expected 0", dut.r_wr_ptr); end
    n_checks++; if (dut.r_wr_bank !== 1'b1) begin n_fail++; $display("FAIL sof_bank: got %b expected 1", dut.r_wr_bank); end
    ppu_sof = 1'b1;
    write_px(6'h21);
    ppu_sof = 1'b0;
    n_checks++; if (dut.r_wr_ptr !== 8'd1) begin n_fail++; $display("FAIL sofpx_ptr: got %0d expected 1", dut.r_wr_ptr); end
    n_checks++; if (dut.r_mem[256] !== 6'h21) begin n_fail++; $display("FAIL sofpx_data: got %h expected 21", dut.r_mem[256]); end
    for (int i = 1; i < 255; i++) write_px(6'(i & 63));
    n_checks++; if (pix_ready !== 1'b1) begin n_fail++; $display("FAIL sof_ready_254: got %b expected 1", pix_ready); end
    write_px(6'(255 & 63));
    n_checks++; if (pix_ready !== 1'b0) begin n_fail++; $display("FAIL sof_ready_full: got %b expected 0", pix_ready); end
    tick();
    n_checks++; if (pix_ready !== 1'b1) begin n_fail++; $display("FAIL sof_swap_ready: got %b expected 1", pix_ready); end
  endtask

  task automatic test_blanking();
    run_line(245, 1'b0, 999, 999);
    n_checks++; if (rgb_log[2] !== 24'h0) begin n_fail++; $display("FAIL blk_rgb: got %h expected 0", rgb_log[2]); end
    n_checks++; if (dut.r_full !== 2'b10) begin n_fail++; $display("FAIL blk_full: got %b expected 10", dut.r_full); end
    run_line(5, 1'b1, 999, 40);
    n_checks++; if (rgb_log[1] !== 24'h3CBCFC) begin n_fail++; $display("FAIL l5_px0: got %h expected 3cbcfc", rgb_log[1]); end
    n_checks++; if (rgb_log[2] !== 24'h0000FC) begin n_fail++; $display("FAIL l5_px1: got %h expected 0000fc", rgb_log[2]); end
    n_checks++; if (rgb_log[41] !== 24'h0) begin n_fail++; $display("FAIL l5_blank_px40: got %h expected 0", rgb_log[41]); end
    n_checks++; if (rgb_log[42] !== 24'hB8F818) begin n_fail++; $display("FAIL l5_px41: got %h expected b8f818", rgb_log[42]); end
  endtask

  initial begin
    test_reset();
    test_fill_display();
    test_backpressure_and_display();
    test_underrun();
    test_midline_sof();
    test_blanking();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nes_line_buffer.md
# nes_line_buffer

Double-buffered scanline store between the PPU pixel stream and the VGA timing generator. The PPU pushes 6-bit palette indices for one 256-pixel line at a time. The VGA side reads them back by `DrawX`/`DrawY`, converts them through the NES master palette, and drives registered 8-bit RGB. Sync and blank are delayed so they stay aligned with the colour. The block decouples the PPU's bursty output from the fixed 256x240 active window of the display.

## Interface
- `LINE_W`, 256: pixels per line; also the active width checked against `DrawX`.
- `LINES`, 240: active lines checked against `DrawY`.
- `Clk` in 1: single system clock, shared by PPU and VGA timing.
- `Reset_n` in 1: synchronous, active-low reset.
- `pix_valid` in 1: PPU pixel present.
- `pix_idx` in 6: palette index.
- `pix_ready` out 1: buffer accepts a pixel.
- `ppu_sof` in 1: one-cycle start-of-frame pulse from the PPU.
- `DrawX`, `DrawY` in 11 each: VGA counters.
- `hs_in`, `vs_in`, `blank_in` in 1 each: VGA controller outputs. `blank_in` is high while displaying.
- `Red`, `Green`, `Blue` out 8 each: registered pixel colour.
- `hs_out`, `vs_out`, `blank_out` out 1 each: `hs_in`, `vs_in`, `blank_in` delayed to match the RGB outputs.
- `underrun` out 1: sticky underrun flag.
- `underrun_cnt` out 16: saturating underrun count.

## Operation
- **Storage:** two banks, each 256 x 6 bits.
  - `wr_bank` selects the bank being written; the read bank is `~wr_bank`.
  - Each bank has a flag, `full[b]`.
- **Write side**
  - `pix_ready = !full[wr_bank]`.
  - On `pix_valid && pix_ready`, store `pix_idx` at `bank[wr_bank][wr_ptr]`, then increment `wr_ptr` (8 bits).
  - When the write lands at `wr_ptr == 255`: set `full[wr_bank]` and wrap `wr_ptr` to 0.
  - `pix_valid` while `pix_ready` is low is ignored; the PPU must hold the pixel.
- **Active window:** `active = (DrawX < LINE_W) && (DrawY < LINES)`.
- **Line start** (`DrawX == 0 && DrawY < LINES`): latch `line_ok = full[rd_bank]`.
- **Line consume** (`DrawX == 255 && DrawY < LINES && line_ok`): clear `full[rd_bank]` on the next edge.
- **Swap:** when `!active && full[wr_bank] && !full[rd_bank]`, toggle `wr_bank`.
  - Swaps never occur inside the active window.
  - A consume and the resulting swap are at least one cycle apart; the swap sees the cleared flag.
- **`ppu_sof`:** clears `full[1:0]` and sets `wr_ptr = 0`. `wr_bank` is unchanged. A pixel accepted in the same cycle is stored at index 0, leaving `wr_ptr = 1`.
- **Read path:** read address `bank[rd_bank][DrawX[7:0]]`; the index is then looked up in a 64-entry NES master palette ROM (2C02 colours, 24-bit).
- **Forced black:** RGB is 0 when the delayed `blank` is low, when `line_ok` was 0 for that line, or when the pixel is outside the active window.
- **Underrun:** a line start with `full[rd_bank] == 0`.

## Timing
- **Reset values:**
  - `Red`, `Green`, `Blue` = 0.
  - `hs_out`, `vs_out` = 1.
  - `blank_out` = 0.
  - `full` = 00; `wr_bank` = 0; `wr_ptr` = 0; `line_ok` = 0.
  - `underrun` = 0; `underrun_cnt` = 0.
- **Reset mid-line:** drops all buffered data. `Reset_n` takes priority over `ppu_sof`, which takes priority over writes.
- **Latency:** 2 cycles from `DrawX`/`DrawY` to RGB.
  - Cycle N+1: bank RAM output registered.
  - Cycle N+2: palette output registered.
  - `hs_out`, `vs_out`, `blank_out` and the black-force qualifier pass through the same 2-stage pipe.
- **Pixel acceptance:** `pix_ready` is combinational from registered flags. Throughput is 1 pixel/cycle until the write bank fills; `pix_ready` falls in the cycle after pixel 255 is written.
- **Post-consume:** the write bank is writable again no earlier than 2 cycles after `DrawX == 255` (clear on the next edge, swap after that).

## Configuration
- **`UNDERRUN_CHECK_EN` defined:**
  - `underrun` sets on any underrun and clears only on reset.
  - `underrun_cnt` increments once per underrun line and saturates at 0xFFFF.
- **`UNDERRUN_CHECK_EN` undefined:** `underrun` and `underrun_cnt` are tied to 0. Display behaviour is identical; underrun lines still output black.

## Test plan
- **Reset:** hold `Reset_n` low 4 cycles -> all outputs at their reset values, `pix_ready = 1`.
- **Fill and display:** stream 256 pixels `idx = x & 63` with `pix_valid = 1`, then run the VGA counters -> `pix_ready` drops after pixel 255 and the second bank is accepted after the swap. On line 0, `DrawX = 1` yields palette[1] RGB at N+2 and `hs_out` equals `hs_in` delayed 2.
- **Back-pressure:** fill both banks with no VGA progress -> `pix_ready = 0` and held pixels are not written. After `DrawX = 255` on an active line, `pix_ready` returns to 1 within 3 cycles.
- **Underrun:** run the VGA with no PPU writes for 3 active lines -> RGB = 0 on those lines. With `UNDERRUN_CHECK_EN`, `underrun = 1` and `underrun_cnt = 3`; without it, both stay 0.
- **Mid-line SOF:** `ppu_sof` after 100 pixels -> `full = 00`, `wr_ptr = 0`. Pulsing `ppu_sof` together with a valid pixel -> the pixel is at index 0 and `wr_ptr = 1`.
- **Blanking:** a full bank with `blank_in = 0` -> RGB = 0 and no `full` clear during blanking lines (`DrawY >= 240`).
